// File: rtl/mem_write_tracer.sv
// rtl/mem_write_tracer.sv - address-filtered, timestamped write-event trace FIFO
//
// Purpose: watches core write strobes (memWr/regWr with direc/datoOut) and
// records qualifying writes into a first-word-fall-through FIFO, each entry
// tagged with a free-running timestamp. Entries drain through a valid/ready
// port.
//
// Optional feature macro: TRACE_REG_EN (register writes are captured when
// defined; regWr is ignored and trc_kind[1] is constant 0 when undefined).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   en, stop_on_full     capture enable, freeze-on-overflow mode
//   memWr, regWr         write strobes from the core
//   direc, datoOut       write address / data
//   win_lo, win_hi       inclusive memWr address window
//   trc_valid/trc_ready  head entry handshake
//   trc_addr/data/ts/kind head entry fields (zero while empty)
//   count                entries held (0..DEPTH)
//   ovf_cnt              saturating dropped-event counter
//   frozen               capture halted after an overflow in stop_on_full mode
module mem_write_tracer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       stop_on_full,
  input  logic                       memWr,
  input  logic                       regWr,
  input  logic [ADDR_W-1:0]          direc,
  input  logic [DATA_W-1:0]          datoOut,
  input  logic [ADDR_W-1:0]          win_lo,
  input  logic [ADDR_W-1:0]          win_hi,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [ADDR_W-1:0]          trc_addr,
  output logic [DATA_W-1:0]          trc_data,
  output logic [TS_W-1:0]            trc_ts,
  output logic [1:0]                 trc_kind,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                ovf_cnt,
  output logic                       frozen
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W + TS_W + 2;

  // Entry layout: {kind, ts, data, addr}
  logic [EW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [15:0]       ovf_q, ovf_d;
  logic              frozen_q, frozen_d;

  logic              mem_hit, reg_hit, evt, push, pop, drop, empty, full;
  logic [EW-1:0]     wr_entry, head;

`ifdef TRACE_REG_EN
  assign reg_hit = regWr;
`else
  logic unused_reg_wr;
  assign reg_hit       = 1'b0;
  assign unused_reg_wr = regWr;
`endif

  always_comb begin
    mem_hit  = memWr && (direc >= win_lo) && (direc <= win_hi);
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop      = !empty && trc_ready;
    evt      = en && !frozen_q && (mem_hit || reg_hit);
    // A pop in the same cycle frees the slot the push needs, so a full
    // FIFO only drops when nothing is leaving.
    push     = evt && (!full || pop);
    drop     = evt && full && !pop;
    wr_entry = {reg_hit, mem_hit, ts_q, datoOut, direc};
    head     = mem_q[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    ts_d  = ts_q + 1'b1;
    ovf_d = (drop && ovf_q != 16'hFFFF) ? ovf_q + 1'b1 : ovf_q;

    // Dropping only happens with en=1, so the set and clear never collide.
    frozen_d = frozen_q;
    if (!en)                       frozen_d = 1'b0;
    else if (drop && stop_on_full) frozen_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ts_q     <= '0;
      ovf_q    <= '0;
      frozen_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ts_q     <= ts_d;
      ovf_q    <= ovf_d;
      frozen_q <= frozen_d;
    end
  end

  // Storage needs no reset: the outputs are forced to zero while empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    trc_valid = !empty;
    {trc_kind, trc_ts, trc_data, trc_addr} = empty ? '0 : head;
    count   = count_q;
    ovf_cnt = ovf_q;
    frozen  = frozen_q;
  end

endmodule

// File: tb/tb_mem_write_tracer.sv
// tb/tb_mem_write_tracer.sv - self-checking bench for mem_write_tracer
module tb_mem_write_tracer;
  localparam int AW = 32, DW = 32, DEPTH = 16, TW = 16;

  logic clk = 1'b0;
  logic rst_n, en, stop_on_full, memWr, regWr, trc_ready;
  logic [AW-1:0] direc, win_lo, win_hi;
  logic [DW-1:0] datoOut;
  logic trc_valid, frozen;
  logic [AW-1:0] trc_addr;
  logic [DW-1:0] trc_data;
  logic [TW-1:0] trc_ts;
  logic [1:0] trc_kind;
  logic [$clog2(DEPTH):0] count;
  logic [15:0] ovf_cnt;

  always #5 clk = ~clk;

  mem_write_tracer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TS_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stop_on_full(stop_on_full),
    .memWr(memWr), .regWr(regWr), .direc(direc), .datoOut(datoOut),
    .win_lo(win_lo), .win_hi(win_hi), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_addr(trc_addr), .trc_data(trc_data), .trc_ts(trc_ts), .trc_kind(trc_kind),
    .count(count), .ovf_cnt(ovf_cnt), .frozen(frozen)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] ts;
    logic [1:0]    kind;
  } entry_t;

  entry_t q[$];
  int m_ts, m_ovf;
  bit m_frozen;
  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: trace queue with the capture rules applied to the
  // inputs presented for this edge.
  task automatic model_edge();
    bit pop, mhit, rhit, ev;
    entry_t e;
    if (!rst_n) begin
      q.delete();
      m_ts = 0; m_ovf = 0; m_frozen = 0;
      return;
    end
    pop  = (q.size() > 0) && trc_ready;
    mhit = memWr && (direc >= win_lo) && (direc <= win_hi);
`ifdef TRACE_REG_EN
    rhit = regWr;
`else
    rhit = 0;
`endif
    ev = en && !m_frozen && (mhit || rhit);
    if (pop) void'(q.pop_front());
    if (ev) begin
      if (q.size() < DEPTH) begin
        e.addr = direc; e.data = datoOut; e.ts = TW'(m_ts); e.kind = {rhit, mhit};
        q.push_back(e);
      end else begin
        if (m_ovf < 16'hFFFF) m_ovf++;
        if (stop_on_full) m_frozen = 1;
      end
    end
    if (!en) m_frozen = 0;
    m_ts = (m_ts + 1) % (1 << TW);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("trc_valid", 64'(trc_valid), 64'(q.size() > 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
    chk("frozen", 64'(frozen), 64'(m_frozen));
    if (q.size() > 0) begin
      chk("trc_addr", 64'(trc_addr), 64'(q[0].addr));
      chk("trc_data", 64'(trc_data), 64'(q[0].data));
      chk("trc_ts", 64'(trc_ts), 64'(q[0].ts));
      chk("trc_kind", 64'(trc_kind), 64'(q[0].kind));
    end else begin
      chk("trc_empty_fields", {trc_kind, trc_ts, trc_addr[13:0]} , 64'd0);
    end
  endtask

  task automatic idle();
    memWr = 0; regWr = 0;
  endtask

  task automatic hit(input logic [AW-1:0] a);
    memWr = 1; regWr = 0; direc = a; datoOut = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 0; idle(); step(); rst_n = 1;
  endtask

  initial begin
    rst_n = 0; en = 1; stop_on_full = 0; memWr = 0; regWr = 0; trc_ready = 0;
    direc = 0; datoOut = 0; win_lo = 32'h100; win_hi = 32'h1FF;

    // Reset state, then first event after 5 idle cycles carries ts=5
    do_reset();
    chk("reset_valid", 64'(trc_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    repeat (5) step();
    hit(32'h150); step();
    chk("first_ts", 64'(trc_ts), 64'd5);
    idle();

    // Window boundaries with draining consumer
    do_reset();
    trc_ready = 1;
    hit(32'h0FF); step();
    hit(32'h100); step();
    hit(32'h1FF); step();
    hit(32'h200); step();
    idle(); repeat (3) step();

    // Overflow, drop-and-count mode
    do_reset();
    trc_ready = 0; stop_on_full = 0;
    for (int i = 0; i < 20; i++) begin hit(32'h100 + i); step(); end
    idle(); step();
    chk("ovf_count16", 64'(count), 64'd16);
    chk("ovf_cnt4", 64'(ovf_cnt), 64'd4);
    trc_ready = 1;
    repeat (17) step();

    // Overflow, freeze mode; drain does not unfreeze; en pulse does
    do_reset();
    trc_ready = 0; stop_on_full = 1;
    for (int i = 0; i < 20; i++) begin hit(32'h180 + i); step(); end
    chk("frz_ovf1", 64'(ovf_cnt), 64'd1);
    chk("frz_frozen", 64'(frozen), 64'd1);
    idle(); trc_ready = 1;
    repeat (16) step();
    for (int i = 0; i < 4; i++) begin hit(32'h110 + i); step(); end
    chk("frz_nothing", 64'(count), 64'd0);
    idle(); en = 0; step(); en = 1;
    chk("frz_cleared", 64'(frozen), 64'd0);
    trc_ready = 0;
    hit(32'h120); step();
    chk("frz_resume", 64'(count), 64'd1);

    // Full with simultaneous pop and push
    do_reset();
    stop_on_full = 0; trc_ready = 0;
    for (int i = 0; i < 16; i++) begin hit(32'h100 + i); step(); end
    trc_ready = 1; hit(32'h1AA); step();
    chk("fullpop_count", 64'(count), 64'd16);
    chk("fullpop_ovf", 64'(ovf_cnt), 64'd0);
    idle(); repeat (17) step();

    // regWr only; empty window
    do_reset();
    trc_ready = 0;
    memWr = 0; regWr = 1; direc = 32'h5; datoOut = 32'hDEAD; step();
    memWr = 1; regWr = 1; direc = 32'h140; step();
    idle();
    win_lo = 32'h200; win_hi = 32'h1FF;
    hit(32'h1FF); step(); hit(32'h200); step();
    idle(); win_lo = 32'h100; win_hi = 32'h1FF;

    // Reset mid-operation with consumer ready
    hit(32'h130); step(); hit(32'h131); step();
    trc_ready = 1; do_reset();
    chk("midreset_valid", 64'(trc_valid), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: direc = win_lo - 1;
        1: direc = win_lo;
        2: direc = win_hi;
        3: direc = win_hi + 1;
        4: direc = $urandom_range(32'h100, 32'h1FF);
        default: direc = $urandom;
      endcase
      datoOut      = $urandom;
      memWr        = ($urandom_range(0, 3) != 0);
      regWr        = ($urandom_range(0, 3) == 0);
      trc_ready    = ($urandom_range(0, 2) == 0);
      en           = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) stop_on_full = ~stop_on_full;
      rst_n        = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
